// File: rtl/mreq_wb_master_pkg.sv
// Shared definitions for the request-to-Wishbone master: word-size codes,
// bytes-per-word lookup and FSM state encoding.
package mreq_wb_master_pkg;

    typedef enum logic [1:0] {
        WSIZE_BYTE     = 2'd0,
        WSIZE_HALF     = 2'd1,
        WSIZE_WORD     = 2'd2,
        WSIZE_WORD_ALT = 2'd3
    } wsize_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_COLLECT = 3'd1,
        ST_WB_CYCLE   = 3'd2,
        ST_RD_EMIT    = 3'd3,
        ST_DONE       = 3'd4
    } state_e;

    // Code 3 is an alias of a full 32-bit word.
    function automatic logic [2:0] bytes_per_word(input logic [1:0] wsize);
        case (wsize_e'(wsize))
            WSIZE_BYTE: return 3'd1;
            WSIZE_HALF: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mreq_wb_master_timeout.sv
// Per-bus-cycle watchdog: cleared by start, frozen by stop, flags expiry once
// the count reaches TIMEOUT_CYCLES while a cycle is outstanding.
module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_reg;
    logic          running_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg   <= '0;
            running_reg <= 1'b0;
        end else if (start) begin
            count_reg   <= '0;
            running_reg <= 1'b1;
        end else if (stop) begin
            running_reg <= 1'b0;
        end else if (running_reg && !expired) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign expired = running_reg && (count_reg == LIMIT);

endmodule

// File: rtl/mreq_wb_master.sv
// Converts a multi-word memory request into Wishbone classic cycles, gathering
// write bytes from the rx stream and serialising read words onto the tx stream.
module mreq_wb_master
    import mreq_wb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mreq_valid,
    output logic        o_mreq_ready,
    input  logic        i_mreq_wr,
    input  logic [1:0]  i_mreq_wsize,
    input  logic        i_mreq_aincr,
    input  logic [7:0]  i_mreq_size,
    input  logic [31:0] i_mreq_addr,
    input  logic        i_rx_data_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_data_ready,
    output logic        o_tx_data_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_data_ready,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic        o_err
);

    state_e       state_reg, state_next;
    logic         wr_reg, aincr_reg, err_reg;
    logic [1:0]   wsize_reg, byte_cnt_reg;
    logic [7:0]   size_reg;
    logic [8:0]   word_cnt_reg;
    logic [31:0]  addr_reg, data_reg;

    logic [2:0]   bpw;
    logic         last_byte, last_word, wb_term, wb_fault, tmo_start, tmo_expired;
    logic [7:0]   lane [4];

    assign bpw       = bytes_per_word(wsize_reg);
    assign last_byte = ({1'b0, byte_cnt_reg} == bpw - 3'd1);
    assign last_word = (word_cnt_reg == {1'b0, size_reg});
    assign wb_term   = (state_reg == ST_WB_CYCLE) && (i_wb_ack || i_wb_err || tmo_expired);
    // err wins over a simultaneous ack; a late ack in the expiry cycle still counts
    assign wb_fault  = i_wb_err || (!i_wb_ack && tmo_expired);
    assign tmo_start = (state_next == ST_WB_CYCLE) && (state_reg != ST_WB_CYCLE);

    wb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (i_clk),
        .rst    (i_rst),
        .start  (tmo_start),
        .stop   (wb_term),
        .expired(tmo_expired)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = data_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_mreq_valid) begin
                    state_next = i_mreq_wr ? ST_WR_COLLECT : ST_WB_CYCLE;
                end
            end
            ST_WR_COLLECT: begin
                if (i_rx_data_valid && last_byte) begin
                    state_next = ST_WB_CYCLE;
                end
            end
            ST_WB_CYCLE: begin
                if (wb_term) begin
                    if (!wr_reg) begin
                        state_next = ST_RD_EMIT;
                    end else begin
                        state_next = last_word ? ST_DONE : ST_WR_COLLECT;
                    end
                end
            end
            ST_RD_EMIT: begin
                if (i_tx_data_ready && last_byte) begin
                    state_next = last_word ? ST_DONE : ST_WB_CYCLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_wb_cyc        = 1'b0;
        o_wb_stb        = 1'b0;
        o_wb_we         = 1'b0;
        o_rx_data_ready = 1'b0;
        o_tx_data_valid = 1'b0;
        o_mreq_ready    = 1'b0;
        case (state_reg)
            ST_WR_COLLECT: o_rx_data_ready = 1'b1;
            ST_WB_CYCLE: begin
                o_wb_cyc = 1'b1;
                o_wb_stb = 1'b1;
                o_wb_we  = wr_reg;
            end
            ST_RD_EMIT:    o_tx_data_valid = 1'b1;
            ST_DONE:       o_mreq_ready    = 1'b1;
            default: ;
        endcase
    end

    // data_reg holds the word being packed for a write or the word read back
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_reg       <= 1'b0;
            aincr_reg    <= 1'b0;
            wsize_reg    <= 2'd0;
            size_reg     <= 8'd0;
            addr_reg     <= 32'd0;
            data_reg     <= 32'd0;
            byte_cnt_reg <= 2'd0;
            word_cnt_reg <= 9'd0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_mreq_valid) begin
                        wr_reg       <= i_mreq_wr;
                        aincr_reg    <= i_mreq_aincr;
                        wsize_reg    <= i_mreq_wsize;
                        size_reg     <= i_mreq_size;
                        addr_reg     <= i_mreq_addr;
                        byte_cnt_reg <= 2'd0;
                        word_cnt_reg <= 9'd0;
                    end
                end
                ST_WR_COLLECT: begin
                    if (i_rx_data_valid) begin
                        if (byte_cnt_reg == 2'd0) begin
                            data_reg <= {24'd0, i_rx_data};
                        end else begin
                            data_reg[{byte_cnt_reg, 3'b000} +: 8] <= i_rx_data;
                        end
                        byte_cnt_reg <= last_byte ? 2'd0 : byte_cnt_reg + 2'd1;
                    end
                end
                ST_WB_CYCLE: begin
                    if (wb_term) begin
                        if (wb_fault) begin
                            err_reg <= 1'b1;
                        end
                        if (aincr_reg) begin
                            addr_reg <= addr_reg + 32'd1;
                        end
                        if (wr_reg) begin
                            word_cnt_reg <= word_cnt_reg + 9'd1;
                        end else begin
                            data_reg <= (i_wb_ack && !i_wb_err) ? i_wb_dat : 32'd0;
                        end
                    end
                end
                ST_RD_EMIT: begin
                    if (i_tx_data_ready) begin
                        byte_cnt_reg <= last_byte ? 2'd0 : byte_cnt_reg + 2'd1;
                        if (last_byte) begin
                            word_cnt_reg <= word_cnt_reg + 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tx_data = lane[byte_cnt_reg];
    assign o_wb_adr  = addr_reg;
    assign o_wb_dat  = data_reg;
    assign o_err     = err_reg;

endmodule

// File: tb/tb_mreq_wb_master.sv
// Randomised bench for mreq_wb_master: a queue-based model of expected bus
// cycles and stream bytes, checked every cycle by a single negedge monitor.
module tb_mreq_wb_master;

    localparam int TMO    = 255;
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_NONE = 2;
    localparam int K_BOTH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_mreq_valid, i_mreq_wr, i_mreq_aincr;
    logic [1:0]  i_mreq_wsize;
    logic [7:0]  i_mreq_size;
    logic [31:0] i_mreq_addr;
    logic        o_mreq_ready;
    logic        i_rx_data_valid, o_rx_data_ready;
    logic [7:0]  i_rx_data;
    logic        o_tx_data_valid, i_tx_data_ready;
    logic [7:0]  o_tx_data;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_adr, o_wb_dat, i_wb_dat;
    logic        i_wb_ack, i_wb_err, o_err;

    mreq_wb_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_mreq_valid(i_mreq_valid), .o_mreq_ready(o_mreq_ready),
        .i_mreq_wr(i_mreq_wr), .i_mreq_wsize(i_mreq_wsize), .i_mreq_aincr(i_mreq_aincr),
        .i_mreq_size(i_mreq_size), .i_mreq_addr(i_mreq_addr),
        .i_rx_data_valid(i_rx_data_valid), .i_rx_data(i_rx_data), .o_rx_data_ready(o_rx_data_ready),
        .o_tx_data_valid(o_tx_data_valid), .o_tx_data(o_tx_data), .i_tx_data_ready(i_tx_data_ready),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat),
        .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        int          kind;
        int          delay;
        logic [31:0] rdata;
    } wb_exp_t;

    wb_exp_t     wb_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    int          n_vec = 0, n_err = 0;
    logic        req_active = 1'b0, exp_err = 1'b0;
    int          bp_after = -1, bp_left = 0, tx_seen = 0;
    int          cyc_len = 0;
    logic        term_prev = 1'b0, term_now, hold_prev = 1'b0;
    logic [7:0]  hold_data, exp_b;
    wb_exp_t     cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                             input int kind, input int delay, input logic [31:0] rdata);
        wb_exp_t e;
        e.adr = adr; e.we = we; e.dat = dat; e.kind = kind; e.delay = delay; e.rdata = rdata;
        wb_q.push_back(e);
    endtask

    // Expected bus cycles and stream bytes straight from the request fields.
    task automatic plan_random(input logic wr, input logic [1:0] wsize, input logic aincr,
                               input logic [7:0] size, input logic [31:0] addr, input int allow_none);
        int b;
        int r;
        logic [7:0] byte_v;
        wb_exp_t e;
        b = (wsize == 2'd0) ? 1 : (wsize == 2'd1) ? 2 : 4;
        for (int w = 0; w <= int'(size); w++) begin
            e.adr   = addr + (aincr ? 32'(w) : 32'd0);
            e.we    = wr;
            e.dat   = 32'd0;
            e.rdata = $urandom;
            e.delay = $urandom_range(0, 4);
            r = $urandom_range(0, 9);
            e.kind  = (r < 7) ? K_ACK : (r < 8) ? K_ERR : (r < 9) ? K_BOTH : (allow_none != 0 ? K_NONE : K_ACK);
            if (e.kind != K_ACK) exp_err = 1'b1;
            for (int k = 0; k < b; k++) begin
                byte_v = 8'($urandom);
                if (wr) begin
                    rx_q.push_back(byte_v);
                    e.dat[8*k +: 8] = byte_v;
                end else begin
                    tx_q.push_back(e.kind == K_ACK ? e.rdata[8*k +: 8] : 8'h00);
                end
            end
            wb_q.push_back(e);
        end
    endtask

    task automatic start_req(input logic wr, input logic [1:0] wsize, input logic aincr,
                             input logic [7:0] size, input logic [31:0] addr);
        @(negedge clk);
        i_mreq_valid = 1'b1; i_mreq_wr = wr; i_mreq_wsize = wsize;
        i_mreq_aincr = aincr; i_mreq_size = size; i_mreq_addr = addr;
        req_active = 1'b1; tx_seen = 0;
        @(negedge clk);
        // fields must be ignored once the request is taken
        i_mreq_valid = 1'b0; i_mreq_wr = 1'($urandom); i_mreq_wsize = 2'($urandom);
        i_mreq_aincr = 1'($urandom); i_mreq_size = 8'($urandom); i_mreq_addr = $urandom;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (req_active && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (req_active) begin
            n_vec++; n_err++;
            $display("FAIL req_timeout: request still active after %0d cycles, required completion", budget);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    endtask

    // Monitor + slave + stream endpoints
    always @(negedge clk) begin
        if (rst) begin
            cyc_len = 0; term_prev = 1'b0; hold_prev = 1'b0;
            i_wb_ack = 1'b0; i_wb_err = 1'b0;
            i_rx_data_valid = 1'b0; i_tx_data_ready = 1'b0;
        end else begin
            term_now = 1'b0;
            i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = $urandom;
            chk("stream_excl", 32'(o_rx_data_ready & (o_tx_data_valid | o_wb_cyc)), 32'd0);
            if (term_prev) chk("cyc_idle_gap", 32'(o_wb_cyc), 32'd0);
            if (o_wb_cyc) begin
                cyc_len++;
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 32'(o_wb_cyc), 32'd0);
                    cyc_len = 0;
                end else begin
                    cur = wb_q[0];
                    chk("wb_adr", o_wb_adr, cur.adr);
                    chk("wb_we", 32'(o_wb_we), 32'(cur.we));
                    chk("wb_stb", 32'(o_wb_stb), 32'd1);
                    if (cur.we) chk("wb_dat", o_wb_dat, cur.dat);
                    if (cur.kind == K_NONE) begin
                        term_now = (cyc_len == TMO + 1);
                    end else if (cyc_len - 1 == cur.delay) begin
                        term_now = 1'b1;
                        i_wb_ack = (cur.kind != K_ERR);
                        i_wb_err = (cur.kind != K_ACK);
                        if (i_wb_ack) i_wb_dat = cur.rdata;
                    end
                    if (term_now) begin
                        void'(wb_q.pop_front());
                        cyc_len = 0;
                    end
                end
            end else if (cyc_len != 0) begin
                chk("wb_cyc_dropped_early", 32'(o_wb_cyc), 32'd1);
                if (wb_q.size() != 0) void'(wb_q.pop_front());
                cyc_len = 0;
            end
            term_prev = term_now;

            if (rx_q.size() != 0 && $urandom_range(0, 3) != 0) begin
                i_rx_data_valid = 1'b1;
                i_rx_data = rx_q[0];
                if (o_rx_data_ready) void'(rx_q.pop_front());
            end else begin
                i_rx_data_valid = 1'b0;
                i_rx_data = 8'($urandom);
            end

            if (o_tx_data_valid) begin
                if (hold_prev) chk("tx_stable", 32'(o_tx_data), 32'(hold_data));
                if (tx_seen == bp_after && bp_left > 0) begin
                    i_tx_data_ready = 1'b0;
                    bp_left--;
                end else begin
                    i_tx_data_ready = ($urandom_range(0, 3) != 0);
                end
                if (i_tx_data_ready) begin
                    if (tx_q.size() == 0) begin
                        chk("tx_unexpected", 32'(o_tx_data_valid), 32'd0);
                    end else begin
                        exp_b = tx_q.pop_front();
                        chk("tx_data", 32'(o_tx_data), 32'(exp_b));
                    end
                    tx_seen++;
                end
                hold_prev = !i_tx_data_ready;
                hold_data = o_tx_data;
            end else begin
                if (hold_prev) chk("tx_valid_held", 32'(o_tx_data_valid), 32'd1);
                hold_prev = 1'b0;
                i_tx_data_ready = ($urandom_range(0, 1) != 0);
            end

            if (o_mreq_ready) begin
                if (req_active) begin
                    chk("done_wb_left", 32'(wb_q.size()), 32'd0);
                    chk("done_rx_left", 32'(rx_q.size()), 32'd0);
                    chk("done_tx_left", 32'(tx_q.size()), 32'd0);
                    chk("err_flag", 32'(o_err), 32'(exp_err));
                    req_active = 1'b0;
                end else begin
                    chk("spurious_ready", 32'(o_mreq_ready), 32'd0);
                end
            end
        end
    end

    logic [7:0]  d23 [5];
    logic [31:0] a23 [5];
    logic        r_wr, r_ai;
    logic [1:0]  r_ws;
    logic [7:0]  r_sz;
    logic [31:0] r_ad;
    int          wait_n;

    initial begin
        rst = 1'b1;
        i_mreq_valid = 1'b0; i_mreq_wr = 1'b0; i_mreq_wsize = 2'd0; i_mreq_aincr = 1'b0;
        i_mreq_size = 8'd0; i_mreq_addr = 32'd0; i_wb_dat = 32'd0;
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_rx_data_valid = 1'b0; i_rx_data = 8'd0;
        i_tx_data_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
        chk("rst_stb", 32'(o_wb_stb), 32'd0);
        chk("rst_we", 32'(o_wb_we), 32'd0);
        chk("rst_adr", o_wb_adr, 32'd0);
        chk("rst_ready", 32'(o_mreq_ready), 32'd0);
        chk("rst_rx_ready", 32'(o_rx_data_ready), 32'd0);
        chk("rst_tx_valid", 32'(o_tx_data_valid), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        rst = 1'b0;

        // Byte writes with address increment
        d23 = '{8'hA3, 8'hA2, 8'hA3, 8'hA2, 8'hA3};
        a23 = '{32'h12345678, 32'h12345679, 32'h1234567A, 32'h1234567B, 32'h1234567C};
        for (int i = 0; i < 5; i++) begin
            rx_q.push_back(d23[i]);
            push_word(a23[i], 1'b1, {24'd0, d23[i]}, K_ACK, i % 3, 32'd0);
        end
        start_req(1'b1, 2'd0, 1'b1, 8'd4, 32'h12345678);
        wait_done(2000);

        // Halfword reads
        for (int i = 0; i < 5; i++) begin
            push_word(32'h87654321 + 32'(i), 1'b0, 32'd0, K_ACK, 1, 32'h0000BEEF);
            tx_q.push_back(8'hEF);
            tx_q.push_back(8'hBE);
        end
        start_req(1'b0, 2'd1, 1'b1, 8'd4, 32'h87654321);
        wait_done(2000);

        // Word writes at a fixed address
        for (int i = 1; i <= 8; i++) rx_q.push_back(8'(i));
        push_word(32'hCAFE0000, 1'b1, 32'h04030201, K_ACK, 0, 32'd0);
        push_word(32'hCAFE0000, 1'b1, 32'h08070605, K_ACK, 2, 32'd0);
        start_req(1'b1, 2'd2, 1'b0, 8'd1, 32'hCAFE0000);
        wait_done(2000);
        chk("err_clean", 32'(o_err), 32'd0);

        // Silent slave: abort after the timeout, zero data, sticky error
        push_word(32'h00000040, 1'b0, 32'd0, K_NONE, 0, 32'd0);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        exp_err = 1'b1;
        start_req(1'b0, 2'd1, 1'b0, 8'd0, 32'h00000040);
        wait_done(2000);
        chk("err_after_timeout", 32'(o_err), 32'd1);

        // tx backpressure for 10 cycles after the first byte
        push_word(32'h00001000, 1'b0, 32'd0, K_ACK, 0, 32'hDDCCBBAA);
        push_word(32'h00001001, 1'b0, 32'd0, K_ACK, 3, 32'h44332211);
        tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        bp_after = 1; bp_left = 10;
        start_req(1'b0, 2'd2, 1'b1, 8'd1, 32'h00001000);
        wait_done(2000);
        chk("bp_applied", 32'(bp_left), 32'd0);
        bp_after = -1;

        // Reset in the middle of a bus cycle
        push_word(32'h00000100, 1'b0, 32'd0, K_NONE, 0, 32'd0);
        start_req(1'b0, 2'd2, 1'b0, 8'd3, 32'h00000100);
        wait_n = 0;
        while (!o_wb_cyc && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        chk("rst_test_cyc_seen", 32'(o_wb_cyc), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_cyc", 32'(o_wb_cyc), 32'd0);
        chk("midrst_stb", 32'(o_wb_stb), 32'd0);
        chk("midrst_ready", 32'(o_mreq_ready), 32'd0);
        wb_q.delete(); rx_q.delete(); tx_q.delete();
        req_active = 1'b0; exp_err = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("err_after_reset", 32'(o_err), 32'd0);
        plan_random(1'b1, 2'd2, 1'b1, 8'd2, 32'h00000200, 0);
        start_req(1'b1, 2'd2, 1'b1, 8'd2, 32'h00000200);
        wait_done(2000);

        // Random requests, including address wrap and a full 256-word burst
        for (int t = 0; t < 24; t++) begin
            r_wr = 1'($urandom);
            r_ws = 2'($urandom);
            r_ai = 1'($urandom);
            r_sz = 8'($urandom_range(0, 7));
            r_ad = $urandom;
            if (t == 5) begin r_ad = 32'hFFFFFFFE; r_ai = 1'b1; r_sz = 8'd3; end
            if (t == 10) begin r_wr = 1'b1; r_ws = 2'd0; r_sz = 8'd255; end
            plan_random(r_wr, r_ws, r_ai, r_sz, r_ad, (t == 15) ? 1 : 0);
            start_req(r_wr, r_ws, r_ai, r_sz, r_ad);
            wait_done(20000);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
